rv_cluster_mem_arb: RTL and testbench
=====================================

# rv_cluster_mem_arb

Parametrised N-to-1 memory arbiter joining the per-core L1 memory ports of a cluster to the single L2-side memory port. Supports round-robin or fixed-priority grant and per-core outstanding-read credit limiting. Requester index travels in the low tag bits; responses are routed back to the issuing core. Request and response paths are each registered, and `busy` reflects in-flight traffic.

## Interface
Parameters:
- NUM_REQS, 4, number of cores (≥1)
- DATA_WIDTH, 512, line data width; BYTEEN_WIDTH = DATA_WIDTH/8
- ADDR_WIDTH, 26, line address width
- TAG_IN_WIDTH, 8, core tag width; LOG_REQS = max(1, clog2(NUM_REQS)); TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS
- MAX_PENDING, 8, max outstanding reads per core (≥1)
- ARB_MODE, "RR", "RR" round-robin or "FIXED" (lowest index wins)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- core_req_valid / core_req_rw  in  NUM_REQS each  request valid / 1 = write
- core_req_byteen  in  NUM_REQS*BYTEEN_WIDTH  byte enables
- core_req_addr  in  NUM_REQS*ADDR_WIDTH  address
- core_req_data  in  NUM_REQS*DATA_WIDTH  write data
- core_req_tag  in  NUM_REQS*TAG_IN_WIDTH  tag
- core_req_ready  out  NUM_REQS  request accepted
- mem_req_valid / mem_req_rw  out  1 each
- mem_req_byteen / addr / data  out  BYTEEN_WIDTH / ADDR_WIDTH / DATA_WIDTH
- mem_req_tag  out  TAG_OUT_WIDTH  {core tag, index}
- mem_req_ready  in  1
- mem_rsp_valid  in  1;  mem_rsp_data  in  DATA_WIDTH;  mem_rsp_tag  in  TAG_OUT_WIDTH
- mem_rsp_ready  out  1
- core_rsp_valid  out  NUM_REQS  one-hot
- core_rsp_data  out  NUM_REQS*DATA_WIDTH  response data replicated to every slice
- core_rsp_tag  out  NUM_REQS*TAG_IN_WIDTH  tag stripped of index, replicated
- core_rsp_ready  in  NUM_REQS
- busy  out  1  traffic in flight
- rsp_err  out  1  one-cycle pulse on an invalid-index response

## Operation
- Eligibility: core i is eligible if core_req_valid[i] and (core_req_rw[i] = 1 or pend[i] < MAX_PENDING).
- Grant: RR picks the first eligible index after last_grant, wrapping. FIXED picks the lowest eligible index. A grant occurs only when the request register is empty or is draining this cycle (mem_req_ready & mem_req_valid).
- core_req_ready[i] = grant[i]; it is one-hot or zero, and combinational from the inputs and state.
- The granted request loads the request register. mem_req_tag = {core_req_tag[i], i[LOG_REQS-1:0]}. last_grant <= i (RR only).
- pend[i] is a $clog2(MAX_PENDING+1)-bit counter:
  - +1 on a granted read.
  - −1 when core_rsp_valid[i] & core_rsp_ready[i].
  - Both in the same cycle: unchanged. Writes never touch pend.
- Response register holds one entry: valid, data, tag, index.
  - mem_rsp_ready = !rsp_valid_r | core_rsp_ready[rsp_idx_r].
  - On mem_rsp handshake, the register loads with index = mem_rsp_tag[LOG_REQS-1:0].
- Index ≥ NUM_REQS (non-power-of-2 NUM_REQS): the response is consumed, not loaded, and rsp_err pulses for 1 cycle. No pend change.
- core_rsp_valid[k] = rsp_valid_r & (rsp_idx_r == k).
- busy = mem_req_valid | rsp_valid_r | (any pend ≠ 0).

## Timing
- Reset (reset = 0 at a clk edge): mem_req_valid = 0, rsp_valid_r = 0, all pend = 0, last_grant = NUM_REQS−1 (first RR grant goes to core 0), rsp_err = 0, busy = 0. Data and tag registers are don't-care.
- Reset mid-operation discards buffered request/response and clears all credits. In-flight responses arriving after reset deassertion are delivered normally. No protection against stale responses.
- Request latency: grant in cycle t → mem_req_valid at t+1. With mem_req_ready held high, throughput is 1 request/cycle.
- mem_req_* stay stable while mem_req_valid & !mem_req_ready.
- Response latency: mem_rsp handshake in cycle t → core_rsp_valid at t+1. Back-to-back at 1/cycle when the target is ready.
- core_rsp outputs stay stable until core_rsp_ready.
- A credit freed in cycle t makes the core eligible in cycle t+1 (pend is registered).

## Test plan
- RR fairness: NUM_REQS=4, all cores request reads continuously, mem_req_ready=1 → grant order 0,1,2,3,0,…; mem_req_tag low 2 bits match.
- FIXED mode: cores 1 and 3 valid every cycle → core 1 always granted, core 3 starved, mem_req_tag[1:0]=1.
- Credit limit: MAX_PENDING=2, core 0 issues reads with no responses → 2 grants, then core_req_ready[0]=0. One response delivered → third grant exactly 1 cycle after delivery. A write from core 0 is granted while the core is blocked on credits.
- Backpressure: mem_req_ready=0 for 5 cycles → mem_req_* frozen, no further grants. Response for core 2 with core_rsp_ready[2]=0 → mem_rsp_ready=0 until ready, data/tag held.
- Invalid index: NUM_REQS=3, response tag low bits = 3 → mem_rsp_ready=1, no core_rsp_valid, rsp_err=1 for one cycle.
- Reset: assert reset low with 2 pending reads and a buffered request → next cycle all valids 0, busy=0, pend=0.

Source files
------------

// File: rtl/rv_cluster_mem_arb.sv
// rv_cluster_mem_arb: N-to-1 arbiter from per-core L1 memory ports onto one L2 memory port
// Ports: clk, reset (sync, active-low); core_req_* in / core_req_ready out per core;
//   mem_req_* out / mem_req_ready in (tag = {core tag, core index});
//   mem_rsp_* in / mem_rsp_ready out; core_rsp_* out (one-hot valid, data/tag replicated) /
//   core_rsp_ready in; busy = traffic in flight; rsp_err = pulse on a response with an unknown index.
module rv_cluster_mem_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_IN_WIDTH = 8,
  parameter int MAX_PENDING = 8,
  parameter string ARB_MODE = "RR",
  localparam int BYTEEN_WIDTH = DATA_WIDTH / 8,
  localparam int LOG_REQS = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              core_req_valid,
  input  logic [NUM_REQS-1:0]              core_req_rw,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] core_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   core_req_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] core_req_tag,
  output logic [NUM_REQS-1:0]              core_req_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]          mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic [NUM_REQS-1:0]              core_rsp_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0]   core_rsp_data,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0] core_rsp_tag,
  input  logic [NUM_REQS-1:0]              core_rsp_ready,
  output logic                             busy,
  output logic                             rsp_err
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam bit FIXED = ARB_MODE == "FIXED";
  logic [LOG_REQS-1:0] last_grant, gidx, j, rsp_idx_r, rsp_in_idx;
  logic [NUM_REQS-1:0] elig, gnt, pend_nz;
  logic [PW-1:0] pend [NUM_REQS];
  logic any_gnt, can_issue, rsp_valid_r, rsp_fire, idx_ok;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic [TAG_IN_WIDTH-1:0] rsp_tag_r;
  // a new request may enter only when the register is empty or emptying this cycle
  assign can_issue = !mem_req_valid | mem_req_ready;
  assign core_req_ready = gnt;
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_core
    assign elig[i] = core_req_valid[i] & (core_req_rw[i] | (pend[i] < PW'(MAX_PENDING)));
    assign pend_nz[i] = |pend[i];
    assign core_rsp_valid[i] = rsp_valid_r & (rsp_idx_r == LOG_REQS'(i));
    always_ff @(posedge clk)
      if (!reset) pend[i] <= '0;
      else pend[i] <= pend[i] + PW'(gnt[i] & !core_req_rw[i]) - PW'(core_rsp_valid[i] & core_rsp_ready[i]);
  end
  // scan starts just after last_grant in RR mode, at index 0 in FIXED mode
  always_comb begin
    gnt = '0;
    gidx = '0;
    j = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      j = LOG_REQS'(FIXED ? k : (int'(last_grant) + 1 + k) % NUM_REQS);
      if (can_issue && !any_gnt && elig[j]) begin
        gnt[j] = 1'b1;
        gidx = j;
        any_gnt = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      mem_req_valid <= 1'b0;
      last_grant <= LOG_REQS'(NUM_REQS - 1);
    end else if (any_gnt) begin
      mem_req_valid <= 1'b1;
      mem_req_rw <= core_req_rw[gidx];
      mem_req_byteen <= core_req_byteen[gidx*BYTEEN_WIDTH +: BYTEEN_WIDTH];
      mem_req_addr <= core_req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_req_data <= core_req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
      mem_req_tag <= {core_req_tag[gidx*TAG_IN_WIDTH +: TAG_IN_WIDTH], gidx};
      last_grant <= FIXED ? last_grant : gidx;
    end else if (mem_req_ready) mem_req_valid <= 1'b0;
  // responses naming a core that does not exist are swallowed and flagged
  assign rsp_in_idx = mem_rsp_tag[LOG_REQS-1:0];
  assign idx_ok = int'(rsp_in_idx) < NUM_REQS;
  assign mem_rsp_ready = !rsp_valid_r | core_rsp_ready[rsp_idx_r];
  assign rsp_fire = mem_rsp_valid & mem_rsp_ready;
  always_ff @(posedge clk)
    if (!reset) begin
      rsp_valid_r <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= rsp_fire & !idx_ok;
      if (rsp_fire && idx_ok) begin
        rsp_valid_r <= 1'b1;
        rsp_data_r <= mem_rsp_data;
        rsp_tag_r <= mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_REQS];
        rsp_idx_r <= rsp_in_idx;
      end else if (rsp_valid_r && core_rsp_ready[rsp_idx_r]) rsp_valid_r <= 1'b0;
    end
  assign core_rsp_data = {NUM_REQS{rsp_data_r}};
  assign core_rsp_tag = {NUM_REQS{rsp_tag_r}};
  assign busy = mem_req_valid | rsp_valid_r | (|pend_nz);
endmodule

// File: tb/tb_rv_cluster_mem_arb.sv
// tb_rv_cluster_mem_arb: directed checks of a 4-core RR arbiter and a 3-core FIXED arbiter
module tb_rv_cluster_mem_arb;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  int total = 0, passed = 0;
  logic [3:0] a_req_valid, a_req_rw, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [7:0] a_req_byteen;
  logic [31:0] a_req_addr;
  logic [63:0] a_req_data, a_rsp_data;
  logic [15:0] a_req_tag, a_rsp_tag, a_mreq_data, a_mrsp_data;
  logic a_mreq_valid, a_mreq_rw, a_mreq_ready, a_mrsp_valid, a_mrsp_ready, a_busy, a_err;
  logic [1:0] a_mreq_byteen;
  logic [7:0] a_mreq_addr;
  logic [5:0] a_mreq_tag, a_mrsp_tag;
  logic [2:0] b_req_valid, b_req_rw, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [5:0] b_req_byteen;
  logic [23:0] b_req_addr;
  logic [47:0] b_req_data, b_rsp_data;
  logic [11:0] b_req_tag, b_rsp_tag;
  logic [15:0] b_mreq_data, b_mrsp_data;
  logic b_mreq_valid, b_mreq_rw, b_mreq_ready, b_mrsp_valid, b_mrsp_ready, b_busy, b_err;
  logic [1:0] b_mreq_byteen;
  logic [7:0] b_mreq_addr;
  logic [5:0] b_mreq_tag, b_mrsp_tag;
  rv_cluster_mem_arb #(.NUM_REQS(4), .DATA_WIDTH(16), .ADDR_WIDTH(8), .TAG_IN_WIDTH(4),
    .MAX_PENDING(2), .ARB_MODE("RR")) dut_a (
    .clk(clk), .reset(reset),
    .core_req_valid(a_req_valid), .core_req_rw(a_req_rw), .core_req_byteen(a_req_byteen),
    .core_req_addr(a_req_addr), .core_req_data(a_req_data), .core_req_tag(a_req_tag),
    .core_req_ready(a_req_ready),
    .mem_req_valid(a_mreq_valid), .mem_req_rw(a_mreq_rw), .mem_req_byteen(a_mreq_byteen),
    .mem_req_addr(a_mreq_addr), .mem_req_data(a_mreq_data), .mem_req_tag(a_mreq_tag),
    .mem_req_ready(a_mreq_ready),
    .mem_rsp_valid(a_mrsp_valid), .mem_rsp_data(a_mrsp_data), .mem_rsp_tag(a_mrsp_tag),
    .mem_rsp_ready(a_mrsp_ready),
    .core_rsp_valid(a_rsp_valid), .core_rsp_data(a_rsp_data), .core_rsp_tag(a_rsp_tag),
    .core_rsp_ready(a_rsp_ready), .busy(a_busy), .rsp_err(a_err));
  rv_cluster_mem_arb #(.NUM_REQS(3), .DATA_WIDTH(16), .ADDR_WIDTH(8), .TAG_IN_WIDTH(4),
    .MAX_PENDING(2), .ARB_MODE("FIXED")) dut_b (
    .clk(clk), .reset(reset),
    .core_req_valid(b_req_valid), .core_req_rw(b_req_rw), .core_req_byteen(b_req_byteen),
    .core_req_addr(b_req_addr), .core_req_data(b_req_data), .core_req_tag(b_req_tag),
    .core_req_ready(b_req_ready),
    .mem_req_valid(b_mreq_valid), .mem_req_rw(b_mreq_rw), .mem_req_byteen(b_mreq_byteen),
    .mem_req_addr(b_mreq_addr), .mem_req_data(b_mreq_data), .mem_req_tag(b_mreq_tag),
    .mem_req_ready(b_mreq_ready),
    .mem_rsp_valid(b_mrsp_valid), .mem_rsp_data(b_mrsp_data), .mem_rsp_tag(b_mrsp_tag),
    .mem_rsp_ready(b_mrsp_ready),
    .core_rsp_valid(b_rsp_valid), .core_rsp_data(b_rsp_data), .core_rsp_tag(b_rsp_tag),
    .core_rsp_ready(b_rsp_ready), .busy(b_busy), .rsp_err(b_err));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  initial begin
    a_req_valid = '0; a_req_rw = '0; a_req_byteen = 8'hFF;
    a_req_addr = {8'h13, 8'h12, 8'h11, 8'h10};
    a_req_data = {16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0};
    a_req_tag = {4'h7, 4'h6, 4'h5, 4'h4};
    a_mreq_ready = 1'b0; a_mrsp_valid = 1'b0; a_mrsp_data = '0; a_mrsp_tag = '0; a_rsp_ready = '0;
    b_req_valid = '0; b_req_rw = '0; b_req_byteen = 6'h3F;
    b_req_addr = {8'h22, 8'h21, 8'h20}; b_req_data = {16'hE2E2, 16'hE1E1, 16'hE0E0};
    b_req_tag = {4'hC, 4'hB, 4'hA};
    b_mreq_ready = 1'b0; b_mrsp_valid = 1'b0; b_mrsp_data = '0; b_mrsp_tag = '0; b_rsp_ready = '0;
    repeat (2) cyc;
    settle;
    chk("rst_a_mreq_valid", a_mreq_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_mreq_valid", b_mreq_valid, 0);
    chk("rst_b_busy", b_busy, 0);
    reset = 1'b1;
    // round robin over all four cores until every core holds two credits
    a_req_valid = 4'hF; a_mreq_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      settle;
      chk("rr_grant", a_req_ready, 64'(4'b1 << (n % 4)));
      if (n > 0) chk("rr_tag", a_mreq_tag, 64'((((n - 1) % 4 + 4) << 2) | ((n - 1) % 4)));
      cyc;
    end
    settle;
    chk("credit_block", a_req_ready, 0);
    chk("rr_tag_last", a_mreq_tag, 6'h1F);
    chk("busy_pend", a_busy, 1);
    // a write bypasses the credit limit
    a_req_rw = 4'h1;
    settle;
    chk("wr_grant", a_req_ready, 4'h1);
    cyc;
    a_req_rw = 4'h0;
    settle;
    chk("wr_rw", a_mreq_rw, 1);
    chk("wr_tag", a_mreq_tag, 6'h10);
    chk("wr_no_credit", a_req_ready, 0);
    cyc;
    // freeing one credit of core 0
    a_rsp_ready = 4'hF; a_mrsp_valid = 1'b1; a_mrsp_tag = {4'h9, 2'd0}; a_mrsp_data = 16'hBEEF;
    settle;
    chk("rsp_accept", a_mrsp_ready, 1);
    cyc;
    a_mrsp_valid = 1'b0;
    settle;
    chk("rsp_valid0", a_rsp_valid, 4'h1);
    chk("rsp_data0", a_rsp_data[15:0], 16'hBEEF);
    chk("rsp_data_rep", a_rsp_data[63:48], 16'hBEEF);
    chk("rsp_tag0", a_rsp_tag[3:0], 4'h9);
    chk("credit_t1", a_req_ready, 0);
    cyc;
    settle;
    chk("credit_t2", a_req_ready, 4'h1);
    cyc;
    // request backpressure holds the buffered core-0 read
    a_mreq_ready = 1'b0; a_req_valid = 4'b0100; a_req_rw = 4'b0100;
    for (int n = 0; n < 5; n++) begin
      settle;
      chk("bp_ready", a_req_ready, 0);
      chk("bp_valid", a_mreq_valid, 1);
      chk("bp_addr", a_mreq_addr, 8'h10);
      chk("bp_tag", a_mreq_tag, 6'h10);
      cyc;
    end
    a_mreq_ready = 1'b1;
    settle;
    chk("bp_release", a_req_ready, 4'b0100);
    cyc;
    a_req_valid = 4'h0;
    settle;
    chk("bp_rw2", a_mreq_rw, 1);
    chk("bp_tag2", a_mreq_tag, 6'h1A);
    chk("bp_addr2", a_mreq_addr, 8'h12);
    chk("bp_data2", a_mreq_data, 16'hD2D2);
    cyc;
    // response backpressure: core 2 not ready, second response must wait
    a_rsp_ready = 4'b1011; a_mrsp_valid = 1'b1; a_mrsp_tag = {4'h3, 2'd2}; a_mrsp_data = 16'h1234;
    settle;
    chk("rbp_accept", a_mrsp_ready, 1);
    cyc;
    a_mrsp_tag = {4'h5, 2'd1}; a_mrsp_data = 16'h5678;
    for (int n = 0; n < 3; n++) begin
      settle;
      chk("rbp_valid", a_rsp_valid, 4'b0100);
      chk("rbp_mready", a_mrsp_ready, 0);
      chk("rbp_data", a_rsp_data[47:32], 16'h1234);
      chk("rbp_tag", a_rsp_tag[11:8], 4'h3);
      cyc;
    end
    a_rsp_ready = 4'hF;
    settle;
    chk("rbp_drain", a_mrsp_ready, 1);
    cyc;
    a_mrsp_valid = 1'b0;
    settle;
    chk("rbp_next_valid", a_rsp_valid, 4'b0010);
    chk("rbp_next_data", a_rsp_data[31:16], 16'h5678);
    chk("rbp_next_tag", a_rsp_tag[7:4], 4'h5);
    cyc;
    // reset with a buffered request and outstanding credits
    a_mreq_ready = 1'b0; a_req_valid = 4'b1000; a_req_rw = 4'b1000;
    settle;
    chk("pre_rst_grant", a_req_ready, 4'b1000);
    cyc;
    a_req_valid = 4'h0;
    settle;
    chk("pre_rst_valid", a_mreq_valid, 1);
    chk("pre_rst_busy", a_busy, 1);
    reset = 1'b0;
    cyc;
    reset = 1'b1;
    settle;
    chk("mid_rst_valid", a_mreq_valid, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_rsp", a_rsp_valid, 0);
    a_req_valid = 4'hF; a_req_rw = 4'h0; a_mreq_ready = 1'b1;
    settle;
    chk("post_rst_grant", a_req_ready, 4'h1);
    cyc;
    a_req_valid = 4'h0;
    // fixed priority: core 1 always beats core 2
    b_req_valid = 3'b110; b_req_rw = 3'b110; b_mreq_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      settle;
      chk("fx_grant", b_req_ready, 3'b010);
      if (n > 0) chk("fx_idx", b_mreq_tag[1:0], 2'd1);
      cyc;
    end
    b_req_valid = 3'b000;
    // response naming nonexistent core 3
    b_rsp_ready = 3'b000; b_mrsp_valid = 1'b1; b_mrsp_tag = {4'hA, 2'd3}; b_mrsp_data = 16'hAAAA;
    settle;
    chk("inv_ready", b_mrsp_ready, 1);
    cyc;
    b_mrsp_valid = 1'b0;
    settle;
    chk("inv_err", b_err, 1);
    chk("inv_rsp_valid", b_rsp_valid, 0);
    cyc;
    settle;
    chk("inv_err_clear", b_err, 0);
    chk("inv_busy", b_busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
